// File: rtl/uart_command_assembler.sv
// -----------------------------------------------------------------------------
// uart_command_assembler
//
// Receives 8N1 operator keystrokes on the board UART and assembles them into a
// 5-character ASCII command word. The first typed character lands in
// command[39:32]. Unused trailing slots are padded with spaces (8'h20).
// CR commits the buffer. BS/DEL delete the last character. Printable bytes
// beyond the fifth are dropped and flagged.
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per UART bit (>= 8), default 100 MHz / 9600 baud
//
// Ports:
//   clk        in   system clock, rising edge
//   reset_n    in   synchronous active-low reset
//   rx         in   asynchronous UART serial line, idle high
//   command    out  [39:0] last committed command, held between commits
//   cmd_valid  out  1-cycle strobe when command takes a new value
//   overflow   out  1-cycle strobe when a printable char is dropped (buffer full)
//   frame_err  out  1-cycle strobe when a stop bit samples low (byte discarded)
//
// Build option:
//   CMD_CASE_FOLD_EN  when defined, 'A'..'Z' are stored as lowercase.
// -----------------------------------------------------------------------------
module uart_command_assembler #(
   parameter int CLKS_PER_BIT = 10416
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        rx,
   output logic [39:0] command,
   output logic        cmd_valid,
   output logic        overflow,
   output logic        frame_err
);

   localparam int DATA_W = 8;
   localparam int CNT_W  = $clog2(CLKS_PER_BIT);
   localparam int HALF   = CLKS_PER_BIT / 2;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

   logic              rx_meta_p0;
   logic              rx_sync_p1;
   logic              rx_prev_p2;
   logic [1:0]        state;
   logic [CNT_W-1:0]  cnt;
   logic [2:0]        bit_idx;
   logic [DATA_W-1:0] shift;
   logic              byte_vld_p3;
   logic [DATA_W-1:0] byte_p3;
   logic [DATA_W-1:0] char_p3;
   logic [39:0]       buffer;
   logic [2:0]        count;

   function automatic logic [DATA_W-1:0] fold_case(input logic [DATA_W-1:0] b);
`ifdef CMD_CASE_FOLD_EN
      if (b >= 8'h41 && b <= 8'h5A) return b + 8'h20;
      return b;
`else
      return b;
`endif
   endfunction

   // Slots at or beyond n may hold stale characters left by backspace, so
   // padding is decided by the count, not by the buffer contents.
   function automatic logic [39:0] pad_command(input logic [39:0] b, input logic [2:0] n);
      logic [39:0] r;
      r = b;
      for (int i = 0; i < 5; i++) begin
         if (3'(i) >= n) r[39-8*i -: 8] = 8'h20;
      end
      return r;
   endfunction

   assign char_p3 = fold_case(byte_p3);

   // ---- stage p0..p2: line synchronizer and falling-edge history ----
   // ---- stage p3: bit-timing FSM, byte_vld_p3 on the stop-sample edge ----
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rx_meta_p0  <= 1'b1;
         rx_sync_p1  <= 1'b1;
         rx_prev_p2  <= 1'b1;
         state       <= S_IDLE;
         cnt         <= '0;
         bit_idx     <= '0;
         shift       <= '0;
         byte_vld_p3 <= 1'b0;
         byte_p3     <= '0;
         frame_err   <= 1'b0;
      end else begin
         rx_meta_p0  <= rx;
         rx_sync_p1  <= rx_meta_p0;
         rx_prev_p2  <= rx_sync_p1;
         byte_vld_p3 <= 1'b0;
         frame_err   <= 1'b0;
         case (state)
            S_IDLE: begin
               cnt <= '0;
               if (rx_prev_p2 && !rx_sync_p1) state <= S_START;
            end
            S_START: begin
               if (cnt == HALF_LAST) begin
                  cnt     <= '0;
                  bit_idx <= '0;
                  // A line already back high at mid-start-bit was a glitch.
                  state   <= rx_sync_p1 ? S_IDLE : S_DATA;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            S_DATA: begin
               if (cnt == BIT_LAST) begin
                  cnt   <= '0;
                  shift <= {rx_sync_p1, shift[DATA_W-1:1]};
                  if (bit_idx == 3'd7) state <= S_STOP;
                  else bit_idx <= bit_idx + 3'd1;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin
               if (cnt == BIT_LAST) begin
                  cnt <= '0;
                  // Leave at mid-stop-bit so a back-to-back start edge is seen.
                  state <= S_IDLE;
                  if (rx_sync_p1) begin
                     byte_vld_p3 <= 1'b1;
                     byte_p3     <= shift;
                  end else begin
                     frame_err <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
         endcase
      end
   end

   // ---- stage p4: command assembler ----
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         command   <= '0;
         cmd_valid <= 1'b0;
         overflow  <= 1'b0;
         buffer    <= '0;
         count     <= '0;
      end else begin
         cmd_valid <= 1'b0;
         overflow  <= 1'b0;
         if (byte_vld_p3) begin
            if (char_p3 == 8'h0D) begin
               if (count != 3'd0) begin
                  command   <= pad_command(buffer, count);
                  cmd_valid <= 1'b1;
                  count     <= '0;
               end
            end else if (char_p3 == 8'h08 || char_p3 == 8'h7F) begin
               if (count != 3'd0) count <= count - 3'd1;
            end else if (char_p3 >= 8'h20 && char_p3 <= 8'h7E) begin
               if (count < 3'd5) begin
                  for (int i = 0; i < 5; i++) begin
                     if (3'(i) == count) buffer[39-8*i -: 8] <= char_p3;
                  end
                  count <= count + 3'd1;
               end else begin
                  overflow <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_command_assembler.sv
// -----------------------------------------------------------------------------
// tb_uart_command_assembler
//
// Drives 8N1 frames (CLKS_PER_BIT = 16) into uart_command_assembler, predicts
// each output strobe with a keystroke-level reference model, queues the
// predictions and lets an independent monitor match every strobe the DUT
// raises against the queue (kind, cycle, command value). The monitor also
// checks every cycle that command holds the last committed value.
// -----------------------------------------------------------------------------
module tb_uart_command_assembler;

   localparam int CPB = 16;
   // Cycle offsets from the cycle the line falls to the strobe: 2 synchronizer
   // flops, 1 edge-detect cycle, half a bit, 9 bit periods; +1 for assembler.
   localparam int FERR_LAT = 3 + CPB/2 + 9*CPB;
   localparam int CMD_LAT  = FERR_LAT + 1;

   localparam int EV_CMD  = 1;
   localparam int EV_OVF  = 2;
   localparam int EV_FERR = 3;

   typedef struct {
      int          kind;
      logic [39:0] val;
      int          t;
   } ev_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        rx = 1'b1;
   logic [39:0] command;
   logic        cmd_valid;
   logic        overflow;
   logic        frame_err;

   int          vectors = 0;
   int          miscompares = 0;
   int          cyc = 0;
   ev_t         exp_q[$];
   logic [7:0]  typed[$];
   logic [39:0] cur_cmd = '0;

   uart_command_assembler #(.CLKS_PER_BIT(CPB)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .rx        (rx),
      .command   (command),
      .cmd_valid (cmd_valid),
      .overflow  (overflow),
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: what an operator's keystroke does to the typed line.
   task automatic model_byte(input logic [7:0] b, input int t0);
      logic [7:0]  c;
      logic [39:0] v;
      ev_t         e;
      c = b;
`ifdef CMD_CASE_FOLD_EN
      if (c >= 8'h41 && c <= 8'h5A) c = c + 8'h20;
`endif
      if (c == 8'h0D) begin
         if (typed.size() > 0) begin
            v = {5{8'h20}};
            for (int i = 0; i < typed.size(); i++) v[39-8*i -: 8] = typed[i];
            e.kind = EV_CMD; e.val = v; e.t = t0 + CMD_LAT;
            exp_q.push_back(e);
            typed.delete();
         end
      end else if (c == 8'h08 || c == 8'h7F) begin
         if (typed.size() > 0) void'(typed.pop_back());
      end else if (c >= 8'h20 && c <= 8'h7E) begin
         if (typed.size() < 5) typed.push_back(c);
         else begin
            e.kind = EV_OVF; e.val = '0; e.t = t0 + CMD_LAT;
            exp_q.push_back(e);
         end
      end
   endtask

   // Called and returns at a negedge; consecutive calls give back-to-back frames.
   task automatic send_frame(input logic [7:0] b, input logic stop_ok);
      int  t0;
      ev_t e;
      t0 = cyc;
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      rx = stop_ok;
      if (stop_ok) model_byte(b, t0);
      else begin
         e.kind = EV_FERR; e.val = '0; e.t = t0 + FERR_LAT;
         exp_q.push_back(e);
      end
      repeat (CPB) @(negedge clk);
      if (!stop_ok) begin
         rx = 1'b1;
         repeat (CPB) @(negedge clk);
      end
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_frame(s[i], 1'b1);
   endtask

   task automatic drain();
      for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
      chk("drain_pending_events", 64'(exp_q.size()), 64'd0);
      repeat (8) @(negedge clk);
   endtask

   // Monitor: every strobe must match the head of the prediction queue.
   always @(posedge clk) begin
      int  n;
      int  kind;
      ev_t e;
      #1;
      if (reset_n) begin
         n = int'(cmd_valid) + int'(overflow) + int'(frame_err);
         chk("pulse_exclusive", 64'(n > 1), 64'd0);
         if (n != 0) begin
            kind = cmd_valid ? EV_CMD : (overflow ? EV_OVF : EV_FERR);
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_pulse: got kind %0d expected none (cycle %0d)", kind, cyc);
            end else begin
               e = exp_q.pop_front();
               chk("pulse_kind", 64'(kind), 64'(e.kind));
               chk("pulse_cycle", 64'(cyc), 64'(e.t));
               if (e.kind == EV_CMD) cur_cmd = e.val;
            end
         end
         chk("command_value", {24'd0, command}, {24'd0, cur_cmd});
      end
   end

   initial begin
      logic [7:0] b;
      int         r;
      reset_n = 1'b0;
      rx = 1'b1;
      repeat (4) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      chk("reset_command", {24'd0, command}, 64'd0);
      chk("reset_cmd_valid", 64'(cmd_valid), 64'd0);
      chk("reset_overflow", 64'(overflow), 64'd0);
      chk("reset_frame_err", 64'(frame_err), 64'd0);
      repeat (2000) @(negedge clk);

      send_str("reset\r");
      drain();
      chk("reset_word", {24'd0, command}, 64'h72_65_73_65_74);

      send_str("sm\r");
      drain();
      chk("sm_word", {24'd0, command}, 64'h73_6D_20_20_20);
      send_str("\r");
      drain();
      chk("lone_cr_hold", {24'd0, command}, 64'h73_6D_20_20_20);

      send_str("abcdef\r");
      drain();
      chk("overflow_word", {24'd0, command}, 64'h61_62_63_64_65);
      send_str("lx");
      send_frame(8'h08, 1'b1);
      send_str("a\r");
      drain();
      chk("backspace_word", {24'd0, command}, 64'h6C_61_20_20_20);

      send_frame(8'h71, 1'b0);
      drain();
      rx = 1'b0;
      repeat (4) @(negedge clk);
      rx = 1'b1;
      repeat (40) @(negedge clk);
      send_str("q\r");
      drain();
      chk("after_err_glitch", {24'd0, command}, 64'h71_20_20_20_20);

      // Reset during the data bits of a frame, with partial typing buffered.
      send_str("ab");
      drain();
      rx = 1'b0;
      repeat (3*CPB) @(negedge clk);
      reset_n = 1'b0;
      rx = 1'b1;
      cur_cmd = '0;
      typed.delete();
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      chk("midreset_command", {24'd0, command}, 64'd0);
      repeat (20) @(negedge clk);
      send_str("z\r");
      drain();
      chk("midreset_word", {24'd0, command}, 64'h7A_20_20_20_20);
      send_str("Z\r");
      drain();

      for (int k = 0; k < 120; k++) begin
         r = int'($urandom_range(0, 99));
         if (r < 50)      b = 8'($urandom_range(8'h20, 8'h7E));
         else if (r < 60) b = 8'($urandom_range(8'h41, 8'h5A));
         else if (r < 75) b = 8'h0D;
         else if (r < 83) b = 8'h08;
         else if (r < 87) b = 8'h7F;
         else if (r < 91) b = 8'($urandom_range(8'h00, 8'h07));
         else if (r < 95) b = 8'($urandom_range(8'h80, 8'hFF));
         else             b = 8'($urandom_range(8'h20, 8'h7E));
         send_frame(b, r < 95);
      end
      send_frame(8'h0D, 1'b1);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/uart_command_assembler.md
# uart_command_assembler

Receives the operator's keystrokes on the board UART line (8N1) and assembles them into the 40-bit, 5-character ASCII `command` word consumed by the `logic` block. This is the producing end of the `command` interface. The first typed character lands in `command[39:32]`, so typing "reset" + Enter yields `{8'h72,8'h65,8'h73,8'h65,8'h74}`. The block holds `command` stable between commits and flags each new command with a one-cycle strobe.

## Interface
- `CLKS_PER_BIT`, default 10416: clk cycles per UART bit (100 MHz / 9600 baud); must be ≥ 8.
- `clk` in 1: system clock; all logic is on the rising edge.
- `reset_n` in 1: synchronous, active-low reset (one clock; reset is synchronous and active-low).
- `rx` in 1: asynchronous UART serial input, idle high.
- `command` out 40: last committed command, first char in [39:32], right-padded with 8'h20.
- `cmd_valid` out 1: one-cycle pulse on the cycle `command` takes a new value.
- `overflow` out 1: one-cycle pulse when a printable char is dropped because the buffer holds 5 chars.
- `frame_err` out 1: one-cycle pulse when a byte's stop bit samples low; that byte is discarded.

## Operation
- Reset values: `command`=40'h0, `cmd_valid`=0, `overflow`=0, `frame_err`=0, char count=0, buffer cleared, RX FSM=IDLE, both `rx` synchronizer flops=1.
- `rx` passes through a 2-flop synchronizer. Start detection uses the synchronized falling edge.
- RX FSM states:
  - IDLE: a falling edge moves to START with the bit counter cleared.
  - START: at count `CLKS_PER_BIT/2` (integer division), re-sample the line. If low, go to DATA. If high, it was a glitch; go back to IDLE with no byte.
  - DATA: sample every `CLKS_PER_BIT` cycles, 8 bits, LSB first, then go to STOP.
  - STOP: sample one `CLKS_PER_BIT` later. If the line is high, raise the internal `byte_valid` for 1 cycle. If low, pulse `frame_err`. In both cases return to IDLE immediately, at mid-stop-bit, so a back-to-back start edge is caught.
- Assembler, acting on `byte_valid`:
  - 8'h0D (CR), count>0: `command` ← buffer with unused slots set to 8'h20; pulse `cmd_valid`; count←0.
  - 8'h0D, count=0: ignored, no pulse, `command` unchanged.
  - 8'h08 or 8'h7F: if count>0, count←count−1 (slot refilled later). At count=0, ignored.
  - Printable 8'h20–8'h7E with count<5: buffer[count] ← byte; count←count+1.
  - Printable with count=5: byte dropped; pulse `overflow`.
  - Any other byte: silently dropped.
- `command` changes only on a commit. Backspace and new typing never disturb it.
- Reset mid-frame or mid-command abandons the partial byte and the buffer. After reset, a start bit is only recognised after `rx` has been seen high.

## Timing
- Bit-sample instants relative to the synchronized falling edge: START check at +`CLKS_PER_BIT/2`; data bit k at +`CLKS_PER_BIT/2`+(k+1)·`CLKS_PER_BIT`; stop bit at +`CLKS_PER_BIT/2`+9·`CLKS_PER_BIT`.
- `byte_valid` is registered on the stop-sample edge. `cmd_valid`, `command`, and `overflow` update on the following edge (1-cycle latency). `frame_err` asserts on the stop-sample edge itself.
- Line-to-output latency also includes the 2-cycle synchronizer delay.
- The output pulses are mutually exclusive for any single byte, and each lasts exactly 1 cycle.
- Minimum line gap: none. Back-to-back frames at the nominal rate must be received without loss.

## Configuration
- `CMD_CASE_FOLD_EN` defined: printable bytes 8'h41–8'h5A ('A'–'Z') are converted to lowercase (+8'h20) before storage, so "RESET" commits as "reset".
- Not defined: bytes are stored unmodified, and uppercase letters reach `command` as typed.

## Test plan
All scenarios use `CLKS_PER_BIT`=16.
- Reset release with `rx` held high: all outputs 0, with no pulses over 2000 cycles.
- Send 'r','e','s','e','t',0x0D: exactly one `cmd_valid`, 1 cycle after the CR stop sample; `command`=40'h7265736574.
- Send 's','m',0x0D: `command`=40'h736D202020. Then send 0x0D alone: no `cmd_valid`, and `command` unchanged.
- Send 'a','b','c','d','e','f',0x0D: one `overflow` pulse on 'f'; `command`=40'h6162636465. Send 'l','x',0x08,'a',0x0D: `command`=40'h6C61202020.
- Send a frame with the stop bit forced low: `frame_err` pulse and the byte ignored. Separately, send a 4-cycle low glitch: no byte and no error.
- Assert `reset_n` low mid-byte, then send 'z',0x0D: `command`=40'h7A20202020. With `CMD_CASE_FOLD_EN`, sending 'Z',0x0D gives the same value.
